if_fetch_queue: RTL
===================

# if_fetch_queue

Parametrised instruction-fetch stage for the pipelined CPU. It drives a synchronous instruction memory and buffers fetched words in a small fetch queue (FQ), so fetch continues while ID stalls. Branch redirects flush the queue and any in-flight fetch. The block sits between the PC/branch logic in ID and the IF/ID boundary.

## Interface
Parameters:
- `PC_W`, 32: PC width; PC is a word address.
- `IMEM_AW`, 8: instruction memory address width.
- `FQ_DEPTH`, 4: queue entries; power of two, at least 2.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  taken branch/jump from ID.
- `redirect_pc`  in  PC_W  branch/jump target.
- `stall`  in  1  ID cannot accept (load-use stall, id_wpcir).
- `imem_addr`  out  IMEM_AW  fetch address.
- `imem_req`  out  1  fetch issued this cycle.
- `imem_rdata`  in  32  memory data; valid one cycle after the request.
- `id_valid`  out  1  queue head is valid.
- `id_inst`  out  32  head instruction; 0 (NOP) when empty.
- `id_pc`  out  PC_W  head PC; 0 when empty.
- `id_pc4`  out  PC_W  `id_pc`+1, mod 2^PC_W.
- `fq_count`  out  $clog2(FQ_DEPTH)+1  current occupancy.

## Operation
- State:
  - `pc`: next fetch address.
  - In-flight flag plus its PC.
  - FQ array with read/write pointers (mod `FQ_DEPTH`) and a count.
- Issue:
  - Normal cycle: `imem_req` = (`fq_count` + inflight < `FQ_DEPTH`).
  - No credit is taken for a same-cycle pop.
  - `imem_addr` = `pc[IMEM_AW-1:0]`.
  - On issue, `pc` <= `pc`+1, wrapping mod 2^PC_W.
- Response:
  - The cycle after an issue, `imem_rdata` and the in-flight PC are pushed into the FQ, unless cancelled.
- Pop:
  - Occurs when `id_valid` && !`stall`.
  - The head is held stable while `stall`=1.
- Redirect (priority over everything):
  - The head is popped if `id_valid` && !`stall` (delay-slot semantics). All other entries are discarded.
  - Any response arriving next cycle from an earlier request is dropped.
  - Same cycle: `imem_req`=1, `imem_addr`=`redirect_pc[IMEM_AW-1:0]`, `pc` <= `redirect_pc`+1. This issue ignores occupancy because the queue is flushed.
- Simultaneous push and pop: count is unchanged.
- Push when full: cannot occur because the issue rule prevents it. The bench asserts this.
- Pop when empty: ignored.

## Timing
- Reset (async assert, sync release):
  - `pc`=`RESET_PC`; count, pointers and inflight = 0.
  - `imem_req`=0 while `rst`=0.
  - `id_valid`=0, `id_inst`=0, `id_pc`=0, `id_pc4`=1, `fq_count`=0.
- First request is in the first cycle after reset release.
- Fetch latency: request in cycle N, data in N+1, head visible in N+2 when the FQ was empty.
- Redirect in cycle N: the target instruction appears at `id_valid` in N+2. No stale instruction is visible in N+1 or N+2.
- Steady state without stall: one instruction per cycle.
- Reset mid-operation: all state is cleared immediately, including in-flight. The response in the cycle after release is ignored.

## Configuration
- `IF_TRACE_EN` defined: adds two ports.
  - `id_ins_number` out 4 = `id_pc[3:0]`.
  - `id_ins_type` out 4 decoded from `id_inst` using the shared `INST_TYPE_*`/`OP_*`/`FUNC_*` encodings.
  - Decoding covers R-type add/sub/and/or/nor/slt/sll/srl/sra, plus addi/andi/ori/lw/sw/beq/bne/j. Anything else is `INST_TYPE_NONE`.
  - `id_ins_type` = `INST_TYPE_NONE` when !`id_valid` or `stall`.
  - Both ports reset to 0.
- `IF_TRACE_EN` undefined: ports and decode logic are absent. Fetch behaviour is identical.

## Test plan
- Reset release, memory word k = 0x1000_0000+k, no stall -> `imem_addr` 0,1,2,... from cycle 1; `id_pc`=0, `id_inst`=0x1000_0000 at cycle 3; then +1 per cycle.
- `stall`=1 for 10 cycles with `FQ_DEPTH`=4 -> `fq_count` saturates at 4 and `imem_req`=0 at full. Head is stable throughout. After release, PCs continue with no gap and no duplicate.
- `redirect`=1, `redirect_pc`=0x40, with 3 entries queued and one in flight -> head popped; `fq_count`=0 next cycle; `id_pc`=0x40 two cycles later; no PC between them is ever delivered.
- `redirect` and `stall` in the same cycle -> flush, head not popped, fetch of target issued.
- `PC_W`=8, `RESET_PC`=0xFE -> fetches 0xFE, 0xFF, 0x00; `id_pc4` of 0xFF = 0x00.
- `IF_TRACE_EN`, head = addi at PC 0x13 -> `id_ins_number`=3, `id_ins_type`=`INST_TYPE_ADD`; with `stall`=1 -> `INST_TYPE_NONE`.

Source files
------------

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch stage. Drives a synchronous instruction memory
//            (one-cycle read latency) and buffers fetched words in a small
//            fetch queue so fetch keeps running while ID stalls. A redirect
//            from ID flushes the queue and cancels any in-flight response.
// Ports    : clk, rst (asynchronous, active-low)
//            redirect / redirect_pc   taken branch or jump from ID
//            stall                    ID cannot accept the head this cycle
//            imem_addr / imem_req     fetch request to instruction memory
//            imem_rdata               memory data, one cycle after request
//            id_valid / id_inst / id_pc / id_pc4   queue head towards ID
//            fq_count                 current queue occupancy
// Options  : IF_TRACE_EN adds id_ins_number / id_ins_type trace ports
//            decoded from the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int              PC_W     = 32,
  parameter int              IMEM_AW  = 8,
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic [PC_W-1:0]           redirect_pc,
  input  logic                      stall,
  output logic [IMEM_AW-1:0]        imem_addr,
  output logic                      imem_req,
  input  logic [31:0]               imem_rdata,
  output logic                      id_valid,
  output logic [31:0]               id_inst,
  output logic [PC_W-1:0]           id_pc,
  output logic [PC_W-1:0]           id_pc4,
  output logic [$clog2(FQ_DEPTH):0] fq_count
`ifdef IF_TRACE_EN
  ,
  output logic [3:0]                id_ins_number,
  output logic [3:0]                id_ins_type
`endif
);

  localparam int                c_PTR_W  = $clog2(FQ_DEPTH);
  localparam int                c_CNT_W  = c_PTR_W + 1;
  localparam logic [PC_W-1:0]   c_PC_ONE = PC_W'(1);
  localparam logic [c_CNT_W:0]  c_DEPTH  = (c_CNT_W + 1)'(FQ_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_W-1:0]    r_pc;            // next sequential fetch address
  logic               r_inflight;      // a request was issued last cycle
  logic [PC_W-1:0]    r_inflight_pc;   // PC of that request
  logic [31:0]        r_fq_inst [FQ_DEPTH];
  logic [PC_W-1:0]    r_fq_pc   [FQ_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [c_CNT_W:0]   w_occupancy;
  logic               w_has_credit;
  logic               w_issue;
  logic [PC_W-1:0]    w_issue_pc;
  logic               w_push;
  logic               w_pop;

  // --------------------------------------------------------------------------
  // Issue
  // --------------------------------------------------------------------------
  // Credit counts both queued words and the word still on its way back from
  // memory. A pop in the same cycle is deliberately not credited, which keeps
  // the credit path free of the ID stall timing.
  assign w_occupancy  = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_has_credit = (w_occupancy < c_DEPTH);

  // A redirect flushes the queue, so its target fetch needs no credit.
  // Requests are held off while reset is asserted.
  assign w_issue    = rst && (redirect || w_has_credit);
  assign w_issue_pc = redirect ? redirect_pc : r_pc;

  assign imem_req  = w_issue;
  assign imem_addr = w_issue_pc[IMEM_AW-1:0];

  // --------------------------------------------------------------------------
  // Queue control
  // --------------------------------------------------------------------------
  assign id_valid = (r_count != '0);
  // On redirect the head may still be consumed (delay slot) if ID is not
  // stalled; the rest of the queue is discarded regardless.
  assign w_pop    = id_valid && !stall;
  // The response belonging to a request issued before a redirect arrives in
  // the redirect cycle itself and is dropped here.
  assign w_push   = r_inflight && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= w_issue_pc;
        r_pc          <= w_issue_pc + c_PC_ONE;
      end

      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage carries no reset: entries are only observed through id_valid.
  // The issue credit guarantees a push never lands on a full queue.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq_inst[r_wr_ptr] <= imem_rdata;
      r_fq_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Head outputs (NOP at PC 0 when empty)
  // --------------------------------------------------------------------------
  assign id_inst  = id_valid ? r_fq_inst[r_rd_ptr] : 32'd0;
  assign id_pc    = id_valid ? r_fq_pc[r_rd_ptr]   : '0;
  assign id_pc4   = id_pc + c_PC_ONE;
  assign fq_count = r_count;

`ifdef IF_TRACE_EN
  // --------------------------------------------------------------------------
  // Trace decode of the queue head
  // --------------------------------------------------------------------------
  localparam logic [3:0] INST_TYPE_NONE = 4'd0;
  localparam logic [3:0] INST_TYPE_ADD  = 4'd1;
  localparam logic [3:0] INST_TYPE_SUB  = 4'd2;
  localparam logic [3:0] INST_TYPE_AND  = 4'd3;
  localparam logic [3:0] INST_TYPE_OR   = 4'd4;
  localparam logic [3:0] INST_TYPE_NOR  = 4'd5;
  localparam logic [3:0] INST_TYPE_SLT  = 4'd6;
  localparam logic [3:0] INST_TYPE_SLL  = 4'd7;
  localparam logic [3:0] INST_TYPE_SRL  = 4'd8;
  localparam logic [3:0] INST_TYPE_SRA  = 4'd9;
  localparam logic [3:0] INST_TYPE_LW   = 4'd10;
  localparam logic [3:0] INST_TYPE_SW   = 4'd11;
  localparam logic [3:0] INST_TYPE_BEQ  = 4'd12;
  localparam logic [3:0] INST_TYPE_BNE  = 4'd13;
  localparam logic [3:0] INST_TYPE_J    = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  logic [5:0] w_op;
  logic [5:0] w_func;
  logic [3:0] w_dec_type;

  assign w_op   = id_inst[31:26];
  assign w_func = id_inst[5:0];

  always_comb begin
    w_dec_type = INST_TYPE_NONE;
    case (w_op)
      OP_RTYPE: begin
        case (w_func)
          FUNC_ADD: w_dec_type = INST_TYPE_ADD;
          FUNC_SUB: w_dec_type = INST_TYPE_SUB;
          FUNC_AND: w_dec_type = INST_TYPE_AND;
          FUNC_OR:  w_dec_type = INST_TYPE_OR;
          FUNC_NOR: w_dec_type = INST_TYPE_NOR;
          FUNC_SLT: w_dec_type = INST_TYPE_SLT;
          FUNC_SLL: w_dec_type = INST_TYPE_SLL;
          FUNC_SRL: w_dec_type = INST_TYPE_SRL;
          FUNC_SRA: w_dec_type = INST_TYPE_SRA;
          default:  w_dec_type = INST_TYPE_NONE;
        endcase
      end
      // Immediate forms report the ALU operation they perform.
      OP_ADDI: w_dec_type = INST_TYPE_ADD;
      OP_ANDI: w_dec_type = INST_TYPE_AND;
      OP_ORI:  w_dec_type = INST_TYPE_OR;
      OP_LW:   w_dec_type = INST_TYPE_LW;
      OP_SW:   w_dec_type = INST_TYPE_SW;
      OP_BEQ:  w_dec_type = INST_TYPE_BEQ;
      OP_BNE:  w_dec_type = INST_TYPE_BNE;
      OP_J:    w_dec_type = INST_TYPE_J;
      default: w_dec_type = INST_TYPE_NONE;
    endcase
  end

  // Only an instruction actually being handed to ID this cycle is traced.
  assign id_ins_type   = (id_valid && !stall) ? w_dec_type : INST_TYPE_NONE;
  assign id_ins_number = id_pc[3:0];
`endif

endmodule
`default_nettype wire
